// File: rtl/i2c_pkg.sv
// Shared types and constants for the write-only I2C master.
package i2c_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StBit,
    StAck,
    StStop,
    StDone
  } i2c_state_e;

  // R/W bit appended to the 7-bit address; this master only writes.
  localparam logic I2C_WR = 1'b0;

  // Address byte, register byte, data byte.
  localparam int unsigned NUM_BYTES = 3;

endpackage

// File: rtl/i2c_bit_timer.sv
// Per-bit phase counter; decodes the SCL level and the SDA update/sample points.
module i2c_bit_timer #(
  parameter int unsigned HALF_CYC = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  output logic o_scl_low,
  output logic o_sda_upd,
  output logic o_sda_smp,
  output logic o_bit_end
);

  localparam int unsigned PhW = $clog2(2 * HALF_CYC);
  localparam logic [PhW-1:0] PhHalf = PhW'(HALF_CYC);
  localparam logic [PhW-1:0] PhUpd  = PhW'(HALF_CYC / 2);
  localparam logic [PhW-1:0] PhSmp  = PhW'(HALF_CYC + HALF_CYC / 2);
  localparam logic [PhW-1:0] PhLast = PhW'(2 * HALF_CYC - 1);

  logic [PhW-1:0] r_ph;

  assign o_scl_low = (r_ph < PhHalf);
  assign o_sda_upd = (r_ph == PhUpd);
  assign o_sda_smp = (r_ph == PhSmp);
  assign o_bit_end = (r_ph == PhLast);

  // Phase counter: held at 0 while idle, wraps at the end of every bit period.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ph <= '0;
    end else if (i_clr || o_bit_end) begin
      r_ph <= '0;
    end else begin
      r_ph <= r_ph + PhW'(1);
    end
  end

endmodule

// File: rtl/i2c_wr_master.sv
// Write-only I2C master: START, {dev_addr,W}, reg_addr, wdata, STOP on open-drain pads.
module i2c_wr_master
  import i2c_pkg::*;
#(
  parameter int unsigned HALF_CYC = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] dev_addr,
  input  logic [7:0] reg_addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       sda_i
);

  i2c_state_e r_state, w_state_nxt;

  logic       r_sda_s1, r_sda_s2;
  logic       r_sda_oe, w_sda_oe_nxt;
  logic [2:0] r_bit, w_bit_nxt;
  logic [1:0] r_byte, w_byte_nxt;
  logic [6:0] r_dev;
  logic [7:0] r_reg, r_wdata;
  logic       r_ack_err, w_ack_err_nxt;
  logic       r_nack, w_nack_nxt;
  logic       w_latch;
  logic [7:0] w_cur_byte;
  logic       w_scl_low, w_sda_upd, w_sda_smp, w_bit_end;

  i2c_bit_timer #(
    .HALF_CYC (HALF_CYC)
  ) u_bit_timer (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (r_state == StIdle),
    .o_scl_low (w_scl_low),
    .o_sda_upd (w_sda_upd),
    .o_sda_smp (w_sda_smp),
    .o_bit_end (w_bit_end)
  );

  // Select the byte currently being shifted out.
  always_comb begin
    unique case (r_byte)
      2'd0:    w_cur_byte = {r_dev, I2C_WR};
      2'd1:    w_cur_byte = r_reg;
      default: w_cur_byte = r_wdata;
    endcase
  end

  // Next-state and datapath next values.
  always_comb begin
    w_state_nxt   = r_state;
    w_sda_oe_nxt  = r_sda_oe;
    w_bit_nxt     = r_bit;
    w_byte_nxt    = r_byte;
    w_ack_err_nxt = r_ack_err;
    w_nack_nxt    = r_nack;
    w_latch       = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_sda_oe_nxt = 1'b0;
        if (start) begin
          w_latch       = 1'b1;
          w_ack_err_nxt = 1'b0;
          w_state_nxt   = StStart;
        end
      end
      StStart: begin
        // SDA falls during the high half of SCL: the START condition.
        if (!w_scl_low) w_sda_oe_nxt = 1'b1;
        if (w_bit_end) begin
          w_state_nxt = StBit;
          w_byte_nxt  = 2'd0;
          w_bit_nxt   = 3'd7;
        end
      end
      StBit: begin
        if (w_sda_upd) w_sda_oe_nxt = ~w_cur_byte[r_bit];
        if (w_bit_end) begin
          if (r_bit == 3'd0) w_state_nxt = StAck;
          else               w_bit_nxt   = r_bit - 3'd1;
        end
      end
      StAck: begin
        if (w_sda_upd) w_sda_oe_nxt = 1'b0;
        if (w_sda_smp) begin
          w_nack_nxt = r_sda_s2;
          if (r_sda_s2) w_ack_err_nxt = 1'b1;
        end
        if (w_bit_end) begin
          if (r_nack || (r_byte == 2'(NUM_BYTES - 1))) begin
            w_state_nxt = StStop;
          end else begin
            w_state_nxt = StBit;
            w_byte_nxt  = r_byte + 2'd1;
            w_bit_nxt   = 3'd7;
          end
        end
      end
      StStop: begin
        // SDA low while SCL low, then rises after SCL is released: the STOP condition.
        if (w_sda_upd) w_sda_oe_nxt = 1'b1;
        if (w_sda_smp) w_sda_oe_nxt = 1'b0;
        if (w_bit_end) w_state_nxt = StDone;
      end
      StDone: begin
        w_sda_oe_nxt = 1'b0;
        w_state_nxt  = StIdle;
      end
      default: begin
        w_sda_oe_nxt = 1'b0;
        w_state_nxt  = StIdle;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= StIdle;
    else      r_state <= w_state_nxt;
  end

  // Two-flop synchroniser for the SDA pad; idles high like the bus.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sda_s1 <= 1'b1;
      r_sda_s2 <= 1'b1;
    end else begin
      r_sda_s1 <= sda_i;
      r_sda_s2 <= r_sda_s1;
    end
  end

  // Datapath registers: SDA drive, bit/byte indices, latched request, ACK status.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sda_oe  <= 1'b0;
      r_bit     <= 3'd0;
      r_byte    <= 2'd0;
      r_dev     <= 7'd0;
      r_reg     <= 8'd0;
      r_wdata   <= 8'd0;
      r_ack_err <= 1'b0;
      r_nack    <= 1'b0;
    end else begin
      r_sda_oe  <= w_sda_oe_nxt;
      r_bit     <= w_bit_nxt;
      r_byte    <= w_byte_nxt;
      r_ack_err <= w_ack_err_nxt;
      r_nack    <= w_nack_nxt;
      if (w_latch) begin
        r_dev   <= dev_addr;
        r_reg   <= reg_addr;
        r_wdata <= wdata;
        r_nack  <= 1'b0;
      end
    end
  end

  assign busy    = (r_state != StIdle) && (r_state != StDone);
  assign done    = (r_state == StDone);
  assign ack_err = r_ack_err;
  assign sda_oe  = r_sda_oe;
  assign scl_oe  = ((r_state == StBit) || (r_state == StAck) || (r_state == StStop)) && w_scl_low;

endmodule

// File: tb/tb_i2c_wr_master.sv
// Bench for i2c_wr_master: table of write transactions against a bus-level slave model.
module tb_i2c_wr_master;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [6:0] dev_addr = 7'd0;
  logic [7:0] reg_addr = 8'd0;
  logic [7:0] wdata = 8'd0;
  wire        busy, done, ack_err, scl_oe, sda_oe;
  logic       slave_pull = 1'b0;
  logic [2:0] nack_mask = 3'b000;
  wire        sda_in = ~sda_oe & ~slave_pull;
  wire        bus_scl = ~scl_oe;

  i2c_wr_master #(
    .HALF_CYC (5)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .dev_addr (dev_addr),
    .reg_addr (reg_addr),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .ack_err  (ack_err),
    .scl_oe   (scl_oe),
    .sda_oe   (sda_oe),
    .sda_i    (sda_in)
  );

  always #5 clk = ~clk;

  // Slave/bus monitor, sampled on the falling clock edge.
  int         cyc = 0, bitcnt = 0, tbyte = 0, nbytes = 0, nrise_t = 0;
  int         last_rise = 0, bad_per = 0, starts = 0, stops = 0;
  logic       prev_scl = 1'b1, prev_sda = 1'b1;
  logic [7:0] shreg = 8'd0;
  logic [7:0] mon_bytes [0:63];

  always @(negedge clk) begin
    cyc      <= cyc + 1;
    prev_scl <= bus_scl;
    prev_sda <= sda_in;
    if (prev_scl && bus_scl && prev_sda && !sda_in) begin
      starts  <= starts + 1;
      bitcnt  <= 0;
      tbyte   <= 0;
      nrise_t <= 0;
    end else if (prev_scl && bus_scl && !prev_sda && sda_in) begin
      stops <= stops + 1;
    end else if (!prev_scl && bus_scl) begin
      if (nrise_t > 0 && (cyc - last_rise) != 10) bad_per <= bad_per + 1;
      last_rise <= cyc;
      nrise_t   <= nrise_t + 1;
      shreg     <= {shreg[6:0], sda_in};
      bitcnt    <= bitcnt + 1;
      if (bitcnt == 7) begin
        mon_bytes[nbytes[5:0]] <= {shreg[6:0], sda_in};
        nbytes <= nbytes + 1;
      end
    end else if (prev_scl && !bus_scl) begin
      if (bitcnt == 8) begin
        slave_pull <= (tbyte < 3) ? ~nack_mask[tbyte[1:0]] : 1'b0;
      end else if (bitcnt == 9) begin
        slave_pull <= 1'b0;
        bitcnt     <= 0;
        tbyte      <= tbyte + 1;
      end
    end
  end

  typedef struct {
    logic [6:0] dev;
    logic [7:0] rg;
    logic [7:0] wd;
    logic [2:0] mask;
    int         exp_lat;
    logic       exp_err;
    int         exp_n;
    logic [7:0] eb0;
    logic [7:0] eb1;
    logic [7:0] eb2;
  } vec_t;

  vec_t vecs [6];
  vec_t vx;
  int   n_chk = 0, n_fail = 0;
  int   base_n, st0, sp0, bp0;
  int   lat;
  logic b1, e1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic snap();
    base_n = nbytes;
    st0    = starts;
    sp0    = stops;
    bp0    = bad_per;
  endtask

  task automatic launch_now(input vec_t vv);
    dev_addr  = vv.dev;
    reg_addr  = vv.rg;
    wdata     = vv.wd;
    nack_mask = vv.mask;
    snap();
    start = 1'b1;
  endtask

  task automatic launch(input vec_t vv);
    @(negedge clk);
    launch_now(vv);
  endtask

  // Counts cycles from the accepting cycle until done; bounded.
  task automatic wait_done(input bit pulses, output int l, output logic bsy1, output logic err1);
    l    = 0;
    bsy1 = 1'b0;
    err1 = 1'b1;
    while (l < 1000) begin
      @(negedge clk);
      l++;
      start = pulses && (l == 50 || l == 200);
      if (start) wdata = 8'h3C;
      if (l == 1) begin
        bsy1 = busy;
        err1 = ack_err;
      end
      if (done) break;
    end
    start = 1'b0;
  endtask

  task automatic verify(input vec_t vv, input string tag, input int l, input logic bsy1,
                        input logic err1);
    logic [7:0] e;
    chk({tag, "_latency"}, l, vv.exp_lat);
    chk({tag, "_busy_c1"}, bsy1, 1'b1);
    chk({tag, "_err_clr"}, err1, 1'b0);
    chk({tag, "_ack_err"}, ack_err, vv.exp_err);
    chk({tag, "_busy_done"}, busy, 1'b0);
    chk({tag, "_lines_rel"}, {scl_oe, sda_oe}, 2'b00);
    chk({tag, "_nbytes"}, nbytes - base_n, vv.exp_n);
    chk({tag, "_starts"}, starts - st0, 1);
    chk({tag, "_stops"}, stops - sp0, 1);
    chk({tag, "_scl_period"}, bad_per - bp0, 0);
    chk({tag, "_scl_rises"}, nrise_t, 9 * vv.exp_n + 1);
    for (int i = 0; i < vv.exp_n; i++) begin
      e = (i == 0) ? vv.eb0 : (i == 1) ? vv.eb1 : vv.eb2;
      chk($sformatf("%s_byte%0d", tag, i), mon_bytes[(base_n + i) % 64], e);
    end
  endtask

  initial begin
    vecs[0] = '{7'h50, 8'h12, 8'hA5, 3'b000, 291, 1'b0, 3, 8'hA0, 8'h12, 8'hA5};
    vecs[1] = '{7'h50, 8'h12, 8'hA5, 3'b001, 111, 1'b1, 1, 8'hA0, 8'h00, 8'h00};
    vecs[2] = '{7'h2D, 8'hC3, 8'h5A, 3'b010, 201, 1'b1, 2, 8'h5A, 8'hC3, 8'h00};
    vecs[3] = '{7'h50, 8'h12, 8'hA5, 3'b100, 291, 1'b1, 3, 8'hA0, 8'h12, 8'hA5};
    vecs[4] = '{7'h7F, 8'hFF, 8'h00, 3'b000, 291, 1'b0, 3, 8'hFE, 8'hFF, 8'h00};
    vecs[5] = '{7'h00, 8'h00, 8'hFF, 3'b000, 291, 1'b0, 3, 8'h00, 8'h00, 8'hFF};

    // Reset held with a running clock, then released.
    repeat (3) @(negedge clk);
    chk("rst_scl_oe", scl_oe, 1'b0);
    chk("rst_sda_oe", sda_oe, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_ack_err", ack_err, 1'b0);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_hold", {scl_oe, sda_oe, busy, done, ack_err}, 5'b00000);

    // Table of transactions with different ACK/NACK patterns.
    for (int v = 0; v < 6; v++) begin
      launch(vecs[v]);
      wait_done(1'b0, lat, b1, e1);
      verify(vecs[v], $sformatf("vec%0d", v), lat, b1, e1);
    end

    // Start pulses while busy must not re-latch wdata.
    launch(vecs[0]);
    wait_done(1'b1, lat, b1, e1);
    verify(vecs[0], "busy_start", lat, b1, e1);

    // Start in the DONE cycle is ignored; the following IDLE cycle accepts it.
    vx = '{7'h50, 8'h12, 8'h3C, 3'b000, 291, 1'b0, 3, 8'hA0, 8'h12, 8'h3C};
    launch_now(vx);
    @(negedge clk);
    chk("b2b_done_ignored", busy, 1'b0);
    wait_done(1'b0, lat, b1, e1);
    verify(vx, "b2b", lat, b1, e1);

    // Asynchronous reset in the middle of byte 1, bit 4 (SCL low, SDA driven low).
    vx = '{7'h50, 8'h00, 8'hA5, 3'b000, 291, 1'b0, 3, 8'hA0, 8'h00, 8'hA5};
    launch(vx);
    for (int k = 1; k <= 134; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #1;
    chk("pre_rst_lines", {scl_oe, sda_oe, busy}, 3'b111);
    rst = 1'b0;
    #1;
    chk("mid_rst_scl_oe", scl_oe, 1'b0);
    chk("mid_rst_sda_oe", sda_oe, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    launch(vecs[0]);
    wait_done(1'b0, lat, b1, e1);
    verify(vecs[0], "post_rst", lat, b1, e1);

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_wr_master.md
Name: i2c_wr_master

Overview:
- Write-only I2C master that consumes the 1 MHz divided clock from the clock-divider stage.
- Derives a 100 kHz SCL from that clock.
- Issues a single-register write transaction: START, {dev_addr,W}, reg_addr, wdata, STOP.
- Drives open-drain pads through output enables and sits between the divider and the board-level I2C pins.

Parameters:
- HALF_CYC, 5, clk cycles per SCL half period (legal range >= 4). Default gives 100 kHz SCL from a 1 MHz clk.

Ports:
- clk  input  1  block clock (1 MHz divided clock)
- rst  input  1  asynchronous, active-low reset
- start  input  1  one-cycle request; accepted only in IDLE
- dev_addr  input  7  7-bit slave address
- reg_addr  input  8  target register
- wdata  input  8  data byte
- busy  output  1  high while a transaction is in progress
- done  output  1  one-cycle pulse at end of transaction (success or abort)
- ack_err  output  1  sticky NACK flag; cleared on next accepted start
- scl_oe  output  1  1 = pull SCL low, 0 = release
- sda_oe  output  1  1 = pull SDA low, 0 = release
- sda_i  input  1  SDA pad input

Behaviour:
- Reset (async, rst=0):
  - State returns to IDLE.
  - scl_oe=0, sda_oe=0, busy=0, done=0, ack_err=0; all counters 0.
  - Reset mid-transfer releases both lines immediately. No bus recovery is attempted.
- sda_i synchronisation: sda_i passes through a 2-flop synchroniser. Only the synchronised value is used.
- Bit period: phase counter ph runs 0..2*HALF_CYC-1 (0..9 at default), wrapping each bit.
  - SCL is low for ph<HALF_CYC and released for ph>=HALF_CYC, except in START.
  - SDA changes at ph==HALF_CYC/2 (floor, =2).
  - SDA is sampled at ph==HALF_CYC+HALF_CYC/2 (=7).
- Start acceptance:
  - In IDLE with start=1: latch dev_addr, reg_addr, wdata; clear ack_err; busy=1 from the next cycle.
  - start while busy is ignored; inputs are not re-latched.
- State machine:
  - IDLE: lines released; wait for start.
  - START (1 bit period): SCL released throughout. sda_oe=0 for ph<HALF_CYC, sda_oe=1 from ph==HALF_CYC. Then go to BIT, byte 0, bit 7.
  - BIT (8 bit periods per byte, MSB first):
    - Bytes are B0={dev_addr,1'b0}, B1=reg_addr, B2=wdata.
    - sda_oe = ~bit, updated at ph==2.
    - After bit 0, go to ACK.
  - ACK (1 bit period):
    - Release SDA at ph==2; sample at ph==7.
    - If sampled 0 (ACK): go to BIT for the next byte, or STOP after B2.
    - If sampled 1 (NACK): set ack_err=1, go to STOP.
  - STOP (1 bit period):
    - SCL low with sda_oe=1 at ph==2.
    - SCL released at ph==HALF_CYC.
    - sda_oe=0 at ph==7.
  - DONE (1 cycle): done=1, busy=0, lines released; return to IDLE.
- Latency (HALF_CYC=5), counted from the cycle start is sampled to the cycle done is high:
  - Full transfer: 1 + 10·(1+27+1) = 291 cycles.
  - NACK on B0: 1 + 10·(1+9+1) = 111.
  - NACK on B1: 201.
  - NACK on B2: 291.
- A start asserted in the DONE cycle is ignored. A start in the following IDLE cycle is accepted.
- Counter widths: ph is $clog2(2*HALF_CYC) bits, bit index is 3 bits, byte index is 2 bits. No other arithmetic.

Decomposition:
- Shared package i2c_pkg:
  - state enum (IDLE, START, BIT, ACK, STOP, DONE)
  - I2C_WR bit constant (1'b0)
  - NUM_BYTES=3
- One natural sub-module: i2c_bit_timer.
  - Phase counter with outputs scl_low, sda_upd (ph==HALF_CYC/2), sda_smp (ph==HALF_CYC+HALF_CYC/2), bit_end (ph==2*HALF_CYC-1).
  - Counter is cleared while IDLE.

Test Plan:
- Reset: hold rst=0 with toggling clk -> scl_oe=0, sda_oe=0, busy=0, done=0, ack_err=0; release rst -> all hold until start.
- Full write: dev_addr=7'h50, reg_addr=8'h12, wdata=8'hA5, slave model ACKs every byte -> bytes 8'hA0, 8'h12, 8'hA5 captured on SCL rising edges, START/STOP conditions seen, SCL period 10 clk, done pulse 291 cycles after start, ack_err=0.
- Address NACK: sda_i held high -> ack_err=1 after first ACK slot, STOP issued, done at cycle 111, no reg_addr bits driven.
- Data NACK: ACK B0/B1, NACK B2 -> ack_err=1, done at cycle 291. Next accepted start clears ack_err.
- Start while busy: second start pulses at cycles 50 and 200 with different wdata=8'h3C -> ignored, transmitted data stays 8'hA5. Back-to-back start one cycle after done -> accepted, busy rises next cycle.
- Reset mid-byte: rst=0 during B1 bit 4 -> scl_oe=0, sda_oe=0, busy=0 immediately (asynchronously). After release, a new transaction completes normally.
